// File: rtl/muldiv_hilo.sv
// Multiply/divide sequencer with HI/LO register pair. Products complete in one
// cycle; divides are launched on an external iterative divider and timed out.
module muldiv_hilo #(
  parameter int DIV_CYCLES = 34
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_sign,
  output logic        div_rst,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_NONE7 = 3'b111
  } op_t;

  state_t        state;
  logic [CW-1:0] cnt;
  op_t           op_e;
  logic          accept;

  assign op_e   = op_t'(op);
  assign busy   = (state != IDLE);
  assign accept = op_valid && (state == IDLE) && (op_e != OP_NONE) && (op_e != OP_NONE7);

  // One 33x33 signed multiplier serves both MULT and MULTU: the extra top bit
  // is the sign for MULT and zero for MULTU. Only the low 64 bits are needed.
  logic               sext;
  logic signed [32:0] mul_a;
  logic signed [32:0] mul_b;
  logic signed [63:0] prod;

  assign sext  = (op_e == OP_MULT);
  assign mul_a = {sext & rs_val[31], rs_val};
  assign mul_b = {sext & rt_val[31], rt_val};
  assign prod  = 64'(mul_a) * 64'(mul_b);

  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      div_a    <= '0;
      div_b    <= '0;
      div_sign <= 1'b0;
      div_rst  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (op_e)
              OP_MULT, OP_MULTU: {hi, lo} <= prod;
              OP_MTHI:           hi <= rs_val;
              OP_MTLO:           lo <= rs_val;
              OP_DIV, OP_DIVU: begin
                if (rt_val == '0) begin
                  // Divide by zero never reaches the divider.
                  hi <= rs_val;
                  lo <= '1;
                end else begin
                  div_a    <= rs_val;
                  div_b    <= rt_val;
                  div_sign <= (op_e == OP_DIV);
                  div_rst  <= 1'b1;
                  state    <= START;
                end
              end
              default: ;
            endcase
          end
        end
        START: begin
          div_rst <= 1'b0;
          cnt     <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            lo    <= div_q;
            hi    <= div_r;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
